// File: rtl/sync_monitor.sv
// Measures CRTC raster timing (line/frame totals, display and sync widths)
// and tracks whether that timing is stable from frame to frame.
module sync_monitor #(
  parameter int HW = 9,
  parameter int VW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSYNC,
  input  logic          VSYNC,
  input  logic          DE,
  output logic [HW-1:0] H_TOTAL,
  output logic [HW-1:0] H_DISP,
  output logic [HW-1:0] HS_WIDTH,
  output logic [VW-1:0] V_TOTAL,
  output logic [VW-1:0] V_DISP,
  output logic [VW-1:0] VS_WIDTH,
  output logic          FRAME,
  output logic          LOCKED,
  output logic          ERR
);

  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;

  typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

  function automatic logic [HW-1:0] hinc(input logic [HW-1:0] v);
    return (v == HMAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [VW-1:0] vinc(input logic [VW-1:0] v);
    return (v == VMAX) ? v : v + 1'b1;
  endfunction

  logic          hs_q, hs_q2, vs_q, vs_q2, de_q;
  logic [HW-1:0] hcnt, de_cnt, hs_cnt;
  logic          de_any, started, fsynced;
  logic [HW-1:0] ln_tot, ln_de, ln_hs;
  logic [VW-1:0] f_tot, f_disp, f_vs;
  state_t        state;

  logic          hs_rise, vs_rise, close, h_to, v_to, timeout, match;
  logic [HW-1:0] lt_n, ld_n, lh_n;
  logic [VW-1:0] ft_n, fd_n, fv_n;

  assign hs_rise = hs_q & ~hs_q2;
  assign vs_rise = vs_q & ~vs_q2;

  // A line is a rise cycle plus everything up to the next rise. The first
  // rise after reset/timeout only opens a line, so partial lines never count.
  assign close = hs_rise & started;

  // "_n" values already include the line closing this cycle, so a VS rise
  // coincident with an HS rise accounts that line to the ending frame.
  assign lt_n = close ? hinc(hcnt) : ln_tot;
  assign ld_n = close ? de_cnt : ln_de;
  assign lh_n = close ? hs_cnt : ln_hs;
  assign ft_n = close ? vinc(f_tot) : f_tot;
  assign fd_n = (close & de_any) ? vinc(f_disp) : f_disp;
  assign fv_n = (close & vs_q) ? vinc(f_vs) : f_vs;

  // Fire once, on the cycle a counter steps into saturation.
  assign h_to    = ~hs_rise & (hcnt == HMAX - 1'b1);
  assign v_to    = close & ~vs_rise & (f_tot == VMAX - 1'b1);
  assign timeout = h_to | v_to;

  // The outputs hold the previous frame's measurements.
  assign match = ({lt_n, ld_n, lh_n} == {H_TOTAL, H_DISP, HS_WIDTH}) &&
                 ({ft_n, fd_n, fv_n} == {V_TOTAL, V_DISP, VS_WIDTH});

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_q    <= 1'b0;
      hs_q2   <= 1'b0;
      vs_q    <= 1'b0;
      vs_q2   <= 1'b0;
      de_q    <= 1'b0;
      hcnt    <= '0;
      de_cnt  <= '0;
      hs_cnt  <= '0;
      de_any  <= 1'b0;
      started <= 1'b0;
      ln_tot  <= '0;
      ln_de   <= '0;
      ln_hs   <= '0;
      f_tot   <= '0;
      f_disp  <= '0;
      f_vs    <= '0;
    end else begin
      hs_q  <= HSYNC;
      hs_q2 <= hs_q;
      vs_q  <= VSYNC;
      vs_q2 <= vs_q;
      de_q  <= DE;
      if (hs_rise) begin
        hcnt    <= '0;
        de_cnt  <= {{(HW-1){1'b0}}, de_q};
        hs_cnt  <= {{(HW-1){1'b0}}, hs_q};
        de_any  <= de_q;
        started <= 1'b1;
      end else begin
        hcnt   <= hinc(hcnt);
        de_cnt <= de_q ? hinc(de_cnt) : de_cnt;
        hs_cnt <= hs_q ? hinc(hs_cnt) : hs_cnt;
        de_any <= de_any | de_q;
        if (h_to) started <= 1'b0;
      end
      ln_tot <= lt_n;
      ln_de  <= ld_n;
      ln_hs  <= lh_n;
      if (vs_rise) begin
        f_tot  <= '0;
        f_disp <= '0;
        f_vs   <= '0;
      end else begin
        f_tot  <= ft_n;
        f_disp <= fd_n;
        f_vs   <= fv_n;
      end
    end
  end

  // The first VS rise after reset/timeout only marks the start of a whole
  // frame; FRAME and the lock state machine act on complete frames only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_SEARCH;
      fsynced  <= 1'b0;
      FRAME    <= 1'b0;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
      H_TOTAL  <= '0;
      H_DISP   <= '0;
      HS_WIDTH <= '0;
      V_TOTAL  <= '0;
      V_DISP   <= '0;
      VS_WIDTH <= '0;
    end else begin
      FRAME <= 1'b0;
      ERR   <= 1'b0;
      if (timeout) begin
        state   <= ST_SEARCH;
        fsynced <= 1'b0;
        LOCKED  <= 1'b0;
        ERR     <= (state == ST_LOCKED);
      end else if (vs_rise) begin
        if (!fsynced) begin
          fsynced <= 1'b1;
        end else begin
          FRAME    <= 1'b1;
          H_TOTAL  <= lt_n;
          H_DISP   <= ld_n;
          HS_WIDTH <= lh_n;
          V_TOTAL  <= ft_n;
          V_DISP   <= fd_n;
          VS_WIDTH <= fv_n;
          case (state)
            ST_SEARCH: state <= ST_ACQUIRE;
            ST_ACQUIRE: begin
              if (match) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
              end
            end
            ST_LOCKED: begin
              if (!match) begin
                state  <= ST_ACQUIRE;
                LOCKED <= 1'b0;
                ERR    <= 1'b1;
              end
            end
            default: begin
              state  <= ST_SEARCH;
              LOCKED <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/sync_monitor.md
SYNC_MONITOR -- requirements
Module: sync_monitor

Interface
REQ-001 SHALL have parameter HW, default 9: width of horizontal measurements, in character clocks.
REQ-002 SHALL have parameter VW, default 10: width of vertical measurements, in lines.
REQ-003 SHALL have port CLK, input, 1: character clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1: reset. There is one clock; reset is synchronous and active-high.
REQ-005 SHALL have port HSYNC, input, 1: horizontal sync from the CRTC, driven on the falling edge of CLK.
REQ-006 SHALL have port VSYNC, input, 1: vertical sync from the CRTC.
REQ-007 SHALL have port DE, input, 1: display enable from the CRTC.
REQ-008 SHALL have port H_TOTAL, output, HW: clocks per line.
REQ-009 SHALL have port H_DISP, output, HW: DE-high clocks per line.
REQ-010 SHALL have port HS_WIDTH, output, HW: HSYNC-high clocks per pulse.
REQ-011 SHALL have port V_TOTAL, output, VW: lines per frame.
REQ-012 SHALL have port V_DISP, output, VW: lines per frame with DE high at least once.
REQ-013 SHALL have port VS_WIDTH, output, VW: lines that begin while VSYNC is high.
REQ-014 SHALL have port FRAME, output, 1: one-cycle strobe; the V_*/H_* outputs were just updated.
REQ-015 SHALL have port LOCKED, output, 1: the timing is stable.
REQ-016 SHALL have port ERR, output, 1: one-cycle strobe on loss of lock.

Function
REQ-017 SHALL register HSYNC, VSYNC and DE once (stage q) and again (stage q2); edge detection uses q against q2 only.
REQ-018 SHALL define an HS rise as hs_q=1 and hs_q2=0; all counters and latches act on the edge after detection (2 CLK edges after the input change).
REQ-019 SHALL clear the line counter on an HS rise, increment it otherwise, and saturate it at 2^HW-1; at an HS rise, line length = counter+1.
REQ-020 SHALL count DE-high clocks and HSYNC-high clocks per line, saturating, cleared at each HS rise after their values are latched into the line registers.
REQ-021 SHALL increment a line counter (VW bits, saturating) on each HS rise; a line counts toward V_DISP if DE was high in any cycle of it, and toward VS_WIDTH if vs_q=1 at its closing HS rise.
REQ-022 SHALL treat a VS rise as a frame boundary: load H_TOTAL/H_DISP/HS_WIDTH from the last completed line, load V_TOTAL/V_DISP/VS_WIDTH from the frame counters, clear the frame counters, and pulse FRAME for 1 cycle.
REQ-023 SHALL, when an HS rise and a VS rise are detected in the same cycle, close the line first and count it in the ending frame.
REQ-024 SHALL implement a lock FSM with states SEARCH, ACQUIRE and LOCKED:
  - SEARCH -> ACQUIRE on the first frame boundary; the values are stored as the previous frame.
  - ACQUIRE -> LOCKED at a frame boundary if all six new values equal the previous ones; otherwise stay in ACQUIRE.
  - LOCKED -> ACQUIRE on any mismatch, with ERR pulsed for 1 cycle.
  - The previous-frame values update at every boundary.
REQ-025 SHALL force SEARCH (ERR pulsed if leaving LOCKED) on a timeout: the line counter saturates (no HSYNC), or the frame line counter saturates (no VSYNC).
REQ-026 SHALL drive LOCKED high only in LOCKED; a partial line after reset SHALL never be latched as valid.

Reset
REQ-027 SHALL, when RST=1 at a CLK edge, clear all counters, sync stages, outputs and previous-frame registers to 0, with FRAME=0, ERR=0, LOCKED=0 and FSM=SEARCH.
REQ-028 SHALL apply reset asserted mid-frame the same way; the first boundary after release only enters ACQUIRE, so LOCKED is reached no earlier than the 2nd boundary.

Verification
REQ-029 SHALL cover a steady stream: 95-clock lines, HS 12 high, DE 76 high, 24-line frames, VS 3 lines, DE on 20 lines -> H_TOTAL=95, H_DISP=76, HS_WIDTH=12, V_TOTAL=24, V_DISP=20, VS_WIDTH=3; LOCKED rises at the 2nd FRAME.
REQ-030 SHALL cover a lock break: from locked, one frame with 96-clock lines -> H_TOTAL=96, ERR one pulse, LOCKED=0, then relock one frame after 95 returns.
REQ-031 SHALL cover a coincident edge: VS and HS rising in the same cycle -> V_TOTAL includes that line (24, not 23).
REQ-032 SHALL cover an HSYNC stuck low for 600 clocks while locked -> timeout at count 511, ERR pulse, FSM=SEARCH, LOCKED=0.
REQ-033 SHALL cover reset mid-frame: RST for 1 cycle at line 10 -> all outputs 0 the next cycle; the 1st FRAME gives LOCKED=0, the 2nd gives LOCKED=1.
REQ-034 SHALL cover the latency check: HSYNC rising at edge n -> line registers update at edge n+2; FRAME high in the cycle after edge n+2 of a VS rise.
